// File: rtl/bin_to_bcd_serial.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_serial
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   Each clock in SHIFT processes one input bit, MSB first, so a conversion
//   takes exactly BIN_W cycles. The result is published as packed BCD
//   together with a leading-zero blank mask for the 7-segment drivers.
//
//   Handshake (both sides): a transfer happens on a rising edge where
//   valid and ready are both high. The producer holds in_valid and in_bin
//   stable until it sees in_ready. out_bcd and out_blank are stable while
//   out_valid is high and out_ready is low. in_ready is high only in IDLE,
//   and out_valid is high only in DONE. in_valid seen in SHIFT or DONE
//   is ignored and is not queued.
//
// Parameters
//   BIN_W    width of the binary input (number of shift cycles)
//   DIGITS   number of BCD digits; 10**DIGITS must exceed 2**BIN_W - 1
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   in_valid   in_bin holds a value to convert
//   in_ready   block can accept (IDLE)
//   in_bin     unsigned binary value
//   out_valid  out_bcd / out_blank hold a finished result
//   out_ready  consumer takes the result
//   out_bcd    packed BCD, [3:0] = ones, [7:4] = tens, ...
//   out_blank  bit i set: digit i is a leading zero (bit 0 is always 0)
//
// Debug visibility: the FSM state is held in the enum signal 'state'.
// ---------------------------------------------------------------------------
module bin_to_bcd_serial #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [DIGITS-1:0]     out_blank
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  // Reset value of the blank mask: every digit except the ones digit blanked,
  // which is exactly the mask for a value of zero.
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [BIN_W-1:0]       bin_sr;
  logic [ACC_W-1:0]       acc;
  logic [CNT_W-1:0]       cnt;

  logic [ACC_W-1:0]       acc_adj;
  logic [ACC_W+BIN_W-1:0] shifted;
  logic [ACC_W-1:0]       acc_next;
  logic [BIN_W-1:0]       bin_next;
  logic [DIGITS-1:0]      blank_next;
  logic                   zero_above;

  logic                   in_fire;
  logic                   out_fire;
  logic                   last_shift;

  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign last_shift = (state == ST_SHIFT) && (cnt == CNT_LAST);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (in_fire)    state_next = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_next = ST_DONE;
      ST_DONE:  if (out_fire)   state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready = (state == ST_IDLE);
  end

  // -------------------------------------------------------------------------
  // Double-dabble step: correct every digit >= 5 by adding 3, then shift the
  // combined {acc, bin} left by one so the binary MSB enters acc bit 0.
  // The correction guarantees no digit exceeds 9 after the shift.
  // -------------------------------------------------------------------------
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
    shifted  = {acc_adj, bin_sr} << 1;
    acc_next = shifted[ACC_W+BIN_W-1:BIN_W];
    bin_next = shifted[BIN_W-1:0];
  end

  // -------------------------------------------------------------------------
  // Leading-zero mask of the value about to be published. Walking from the
  // top digit down, a digit is blanked while it and every digit above it are
  // zero. The ones digit is never blanked.
  // -------------------------------------------------------------------------
  always_comb begin
    blank_next = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above & (acc_next[4*i +: 4] == 4'd0);
      blank_next[i] = zero_above;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sr    <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_bcd   <= '0;
      out_blank <= BLANK_RST;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_fire) begin
            bin_sr <= in_bin;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        ST_SHIFT: begin
          acc    <= acc_next;
          bin_sr <= bin_next;
          cnt    <= cnt + CNT_W'(1);
          // The final shift result goes straight to the output registers,
          // so out_valid rises on the same edge that enters DONE.
          if (cnt == CNT_LAST) begin
            out_bcd   <= acc_next;
            out_blank <= blank_next;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
module tb_bin_to_bcd_serial;

  localparam int BIN_W  = 8;
  localparam int DIGITS = 3;
  localparam int EXP_W  = DIGITS + 4 * DIGITS;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [BIN_W-1:0]    in_bin;
  logic                out_valid;
  logic                out_ready;
  logic [4*DIGITS-1:0] out_bcd;
  logic [DIGITS-1:0]   out_blank;

  int n_vec;
  int n_err;

  // Expected {out_blank, out_bcd}, pushed on acceptance, popped on output.
  logic [EXP_W-1:0] exp_q[$];

  bin_to_bcd_serial #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_blank (out_blank)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: decimal digits by division, blank mask by magnitude.
  function automatic logic [EXP_W-1:0] model(input int v);
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   blank;
    int                  rest;
    int                  pow;
    rest  = v;
    pow   = 1;
    bcd   = '0;
    blank = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd[4*i +: 4] = 4'(rest % 10);
      rest = rest / 10;
      if (i > 0) blank[i] = (v < pow);
      pow = pow * 10;
    end
    return {blank, bcd};
  endfunction

  // ---------------------------------------------------------------- monitor
  // Runs on the falling edge; inputs only change #1 after a rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(out_valid), 32'(0));
      end else begin
        if (out_ready) begin
          check("result", 32'({out_blank, out_bcd}), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end else begin
          check("held_result", 32'({out_blank, out_bcd}), 32'(exp_q[0]));
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver
  // One full conversion: offer v, check latency, hold off out_ready for
  // 'hold' cycles, then take the result. poke pulses a stray in_valid
  // during SHIFT.
  task automatic convert(input logic [BIN_W-1:0] v, input int hold, input bit poke);
    int waited;
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_bin   = v;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("accept_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;          // acceptance edge
    exp_q.push_back(model(int'(v)));
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (poke && lat == 2) begin
        in_valid = 1'b1;
        in_bin   = 8'd77;
      end else if (poke && lat == 3) begin
        in_valid = 1'b0;
      end
      check("busy_in_ready", 32'(in_ready), 32'(0));
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 32'(lat), 32'(BIN_W));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'(1));
      check("bp_in_ready", 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("back_to_idle", 32'(in_ready), 32'(1));
    check("valid_cleared", 32'(out_valid), 32'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bcd"},   32'(out_bcd),   32'(0));
    check({tag, "_blank"}, 32'(out_blank), 32'(3'b110));
    check({tag, "_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_ready"}, 32'(in_ready),  32'(1));
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    int seen;
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bin    = '0;
    out_ready = 1'b0;
    #3;
    check_reset_values("rst_initial");
    @(negedge clk);
    rst = 1'b0;

    // Async reset mid-cycle, after a result has loaded.
    convert(8'd255, 0, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_reset_values("rst_async");
    #1;
    rst = 1'b0;

    // Directed values and boundaries.
    convert(8'd0,   0, 1'b0);
    convert(8'd255, 0, 1'b0);
    convert(8'd99,  0, 1'b0);
    convert(8'd9,   0, 1'b0);
    convert(8'd10,  0, 1'b0);
    convert(8'd100, 0, 1'b0);

    // Backpressure for 5 cycles.
    convert(8'd147, 5, 1'b0);

    // Stray in_valid during SHIFT.
    convert(8'd200, 0, 1'b1);
    repeat (12) begin
      @(posedge clk); #1;
      check("no_stray_out", 32'(out_valid), 32'(0));
    end

    // Reset during SHIFT discards the conversion.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_bin   = 8'd123;
    @(posedge clk); #1;          // accepted
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("rst_shift");
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("discarded_out", 32'(seen), 32'(0));
    convert(8'd42, 0, 1'b0);

    // Full sweep with occasional random backpressure.
    for (int v = 0; v < 256; v++) begin
      convert(8'(v), ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
